// File: rtl/beta_pkg.sv
// Beta ISA constants and instruction-field helpers shared by the register-fetch stage.
package beta_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [5:0] OP_LD  = 6'h18;
    localparam logic [5:0] OP_ST  = 6'h19;
    localparam logic [5:0] OP_JMP = 6'h1B;
    localparam logic [5:0] OP_BEQ = 6'h1C;
    localparam logic [5:0] OP_BNE = 6'h1D;
    localparam logic [5:0] OP_LDR = 6'h1F;

    localparam logic [4:0] REG_ZERO = 5'd31;

    function automatic logic [5:0] inst_op(input logic [31:0] inst);
        return inst[31:26];
    endfunction

    function automatic logic [4:0] inst_rc(input logic [31:0] inst);
        return inst[25:21];
    endfunction

    function automatic logic [4:0] inst_ra(input logic [31:0] inst);
        return inst[20:16];
    endfunction

    function automatic logic [4:0] inst_rb(input logic [31:0] inst);
        return inst[15:11];
    endfunction

    function automatic logic signed [DATA_W-1:0] inst_lit_sext(input logic [31:0] inst);
        return DATA_W'(signed'(inst[15:0]));
    endfunction

    function automatic logic is_op_reg(input logic [5:0] op);
        return op[5:4] == 2'b10;
    endfunction

    function automatic logic is_op_lit(input logic [5:0] op);
        return op[5:4] == 2'b11;
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return is_op_reg(op) || is_op_lit(op) || op == OP_LD || op == OP_ST ||
               op == OP_JMP || op == OP_BEQ || op == OP_BNE || op == OP_LDR;
    endfunction

endpackage

// File: rtl/operand_bypass.sv
// Resolves one source register: ALU > MEM > WB > file, with r31 hardwired to zero.
module operand_bypass
    import beta_pkg::*;
(
    input  logic              used,
    input  logic [4:0]        src,
    input  logic [DATA_W-1:0] file_data,
    input  logic              alu_wen,
    input  logic [4:0]        alu_wa,
    input  logic [DATA_W-1:0] alu_wd,
    input  logic              alu_wd_ok,
    input  logic              mem_wen,
    input  logic [4:0]        mem_wa,
    input  logic [DATA_W-1:0] mem_wd,
    input  logic              mem_wd_ok,
    input  logic              wb_wen,
    input  logic [4:0]        wb_wa,
    input  logic [DATA_W-1:0] wb_wd,
    output logic [DATA_W-1:0] value,
    output logic              hazard
);

    always_comb begin
        value  = '0;
        hazard = 1'b0;
        if (src != REG_ZERO) begin
            if (alu_wen && alu_wa == src) begin
                value  = alu_wd;
                hazard = used && !alu_wd_ok;
            end else if (mem_wen && mem_wa == src) begin
                value  = mem_wd;
                hazard = used && !mem_wd_ok;
            end else if (wb_wen && wb_wa == src) begin
                value  = wb_wd;
            end else begin
                value  = file_data;
            end
        end
    end

endmodule

// File: rtl/reg_fetch_stage.sv
// Beta register-fetch stage: decode, operand bypass, hazard stall and the RF/ALU register.
module reg_fetch_stage
    import beta_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_inst,
    input  logic [31:0] if_pc,
    output logic        rf_stall,
    output logic [5:0]  ra1,
    output logic [5:0]  ra2,
    input  logic [31:0] rd1,
    input  logic [31:0] rd2,
    input  logic        alu_wen,
    input  logic        mem_wen,
    input  logic        wb_wen,
    input  logic [4:0]  alu_wa,
    input  logic [4:0]  mem_wa,
    input  logic [4:0]  wb_wa,
    input  logic [31:0] alu_wd,
    input  logic [31:0] mem_wd,
    input  logic [31:0] wb_wd,
    input  logic        alu_wd_ok,
    input  logic        mem_wd_ok,
    input  logic        ex_hold,
    input  logic        flush,
    output logic        rf_valid,
    output logic [31:0] rf_inst,
    output logic [31:0] rf_pc,
    output logic [31:0] rf_a,
    output logic [31:0] rf_b,
    output logic [31:0] rf_st_data,
    output logic        rf_illop
);

    logic [5:0]  op;
    logic [4:0]  src1, src2;
    logic        st, op_reg, legal;
    logic        use1, use2, haz1, haz2, hazard;
    logic [31:0] val1, val2;

    assign op     = inst_op(if_inst);
    assign st     = (op == OP_ST);
    assign op_reg = is_op_reg(op);
    assign legal  = is_legal(op);
    assign src1   = inst_ra(if_inst);
    assign src2   = st ? inst_rc(if_inst) : inst_rb(if_inst);
    assign ra1    = {1'b0, src1};
    assign ra2    = {1'b0, src2};

    // Only sources the instruction actually reads may raise a hazard.
    assign use1 = if_valid && legal && (op != OP_LDR);
    assign use2 = if_valid && (op_reg || st);

    operand_bypass u_src1 (
        .used(use1), .src(src1), .file_data(rd1),
        .alu_wen(alu_wen), .alu_wa(alu_wa), .alu_wd(alu_wd), .alu_wd_ok(alu_wd_ok),
        .mem_wen(mem_wen), .mem_wa(mem_wa), .mem_wd(mem_wd), .mem_wd_ok(mem_wd_ok),
        .wb_wen(wb_wen), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .value(val1), .hazard(haz1)
    );

    operand_bypass u_src2 (
        .used(use2), .src(src2), .file_data(rd2),
        .alu_wen(alu_wen), .alu_wa(alu_wa), .alu_wd(alu_wd), .alu_wd_ok(alu_wd_ok),
        .mem_wen(mem_wen), .mem_wa(mem_wa), .mem_wd(mem_wd), .mem_wd_ok(mem_wd_ok),
        .wb_wen(wb_wen), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .value(val2), .hazard(haz2)
    );

    assign hazard   = haz1 || haz2;
    assign rf_stall = if_valid && (ex_hold || hazard) && !flush;

    // RF/ALU pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_valid   <= 1'b0;
            rf_inst    <= '0;
            rf_pc      <= '0;
            rf_a       <= '0;
            rf_b       <= '0;
            rf_st_data <= '0;
            rf_illop   <= 1'b0;
        end else if (!ex_hold) begin
            if (flush || hazard) begin
                rf_valid <= 1'b0;
            end else begin
                rf_valid   <= if_valid;
                rf_inst    <= if_inst;
                rf_pc      <= if_pc;
                rf_a       <= val1;
                rf_b       <= op_reg ? val2 : inst_lit_sext(if_inst);
                rf_st_data <= st ? val2 : '0;
                rf_illop   <= if_valid && !legal;
            end
        end
    end

endmodule

// File: tb/tb_reg_fetch_stage.sv
// Directed and random checks of reg_fetch_stage against a behavioural operand/stall model.
module tb_reg_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_inst = '0, if_pc = '0;
    logic        rf_stall;
    logic [5:0]  ra1, ra2;
    logic [31:0] rd1, rd2;
    logic        alu_wen = 1'b0, mem_wen = 1'b0, wb_wen = 1'b0;
    logic [4:0]  alu_wa = '0, mem_wa = '0, wb_wa = '0;
    logic [31:0] alu_wd = '0, mem_wd = '0, wb_wd = '0;
    logic        alu_wd_ok = 1'b1, mem_wd_ok = 1'b1;
    logic        ex_hold = 1'b0, flush = 1'b0;
    logic        rf_valid, rf_illop;
    logic [31:0] rf_inst, rf_pc, rf_a, rf_b, rf_st_data;

    logic [31:0] file_m [32];
    logic        e_valid = 1'b0, e_ill = 1'b0;
    logic [31:0] e_inst = '0, e_pc = '0, e_a = '0, e_b = '0, e_st = '0;

    int total = 0;
    int bad = 0;

    assign rd1 = file_m[ra1[4:0]];
    assign rd2 = file_m[ra2[4:0]];

    always #5 clk = ~clk;

    reg_fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .rf_stall(rf_stall), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .alu_wen(alu_wen), .mem_wen(mem_wen), .wb_wen(wb_wen),
        .alu_wa(alu_wa), .mem_wa(mem_wa), .wb_wa(wb_wa),
        .alu_wd(alu_wd), .mem_wd(mem_wd), .wb_wd(wb_wd),
        .alu_wd_ok(alu_wd_ok), .mem_wd_ok(mem_wd_ok),
        .ex_hold(ex_hold), .flush(flush),
        .rf_valid(rf_valid), .rf_inst(rf_inst), .rf_pc(rf_pc), .rf_a(rf_a), .rf_b(rf_b),
        .rf_st_data(rf_st_data), .rf_illop(rf_illop)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    // Returns {pending, value} for a register as seen by an instruction in RF.
    function automatic logic [32:0] resolve(input logic [4:0] r);
        logic        en [3];
        logic [4:0]  wa [3];
        logic [31:0] wd [3];
        logic        ok [3];
        en = '{alu_wen, mem_wen, wb_wen};
        wa = '{alu_wa, mem_wa, wb_wa};
        wd = '{alu_wd, mem_wd, wb_wd};
        ok = '{alu_wd_ok, mem_wd_ok, 1'b1};
        if (r == 5'd31) return 33'd0;
        for (int s = 0; s < 3; s++)
            if (en[s] && wa[s] == r) return {~ok[s], wd[s]};
        return {1'b0, file_m[r]};
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rc,
                                       input logic [4:0] ra, input logic [15:0] low);
        return {op, rc, ra, low};
    endfunction

    function automatic logic [4:0] rreg();
        if ($urandom_range(0, 5) == 0) return 5'd31;
        return 5'($urandom_range(0, 7));
    endfunction

    task automatic check_regs();
        chk1("rf_valid", rf_valid, e_valid);
        chk("rf_inst", rf_inst, e_inst);
        chk("rf_pc", rf_pc, e_pc);
        chk("rf_a", rf_a, e_a);
        chk("rf_b", rf_b, e_b);
        chk("rf_st_data", rf_st_data, e_st);
        chk1("rf_illop", rf_illop, e_ill);
    endtask

    task automatic clear_model();
        e_valid = 1'b0; e_ill = 1'b0;
        e_inst = '0; e_pc = '0; e_a = '0; e_b = '0; e_st = '0;
    endtask

    // Inputs must already be set; checks combinational outputs, then one edge.
    task automatic step();
        logic [5:0]  op;
        logic [4:0]  s2reg;
        logic [32:0] s1, s2;
        logic        st, opreg, legal, u1, u2, haz;
        #1;
        op    = if_inst[31:26];
        st    = (op == 6'h19);
        opreg = (op >= 6'h20 && op <= 6'h2F);
        legal = (op >= 6'h20) || (op inside {6'h18, 6'h19, 6'h1B, 6'h1C, 6'h1D, 6'h1F});
        u1    = if_valid && legal && op != 6'h1F;
        u2    = if_valid && (opreg || st);
        s2reg = st ? if_inst[25:21] : if_inst[15:11];
        s1    = resolve(if_inst[20:16]);
        s2    = resolve(s2reg);
        haz   = (u1 && s1[32]) || (u2 && s2[32]);
        chk1("rf_stall", rf_stall, if_valid && !flush && (ex_hold || haz));
        chk("ra1", {26'b0, ra1}, {27'b0, if_inst[20:16]});
        chk("ra2", {26'b0, ra2}, {27'b0, s2reg});
        @(posedge clk);
        #1;
        if (!ex_hold) begin
            if (flush || haz) begin
                e_valid = 1'b0;
            end else begin
                e_valid = if_valid;
                e_inst  = if_inst;
                e_pc    = if_pc;
                e_a     = s1[31:0];
                e_b     = opreg ? s2[31:0] : {{16{if_inst[15]}}, if_inst[15:0]};
                e_st    = st ? s2[31:0] : 32'd0;
                e_ill   = if_valid && !legal;
            end
        end
        check_regs();
    endtask

    task automatic idle_stages();
        alu_wen = 1'b0; mem_wen = 1'b0; wb_wen = 1'b0;
        alu_wd_ok = 1'b1; mem_wd_ok = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) file_m[i] = $urandom;
        file_m[2]  = 32'd5;
        file_m[3]  = 32'd7;
        file_m[6]  = 32'h0000_0066;
        file_m[31] = 32'hDEAD_BEEF;

        repeat (2) @(posedge clk);
        #1;
        check_regs();
        chk1("reset_stall", rf_stall, 1'b0);
        rst_n = 1'b1;

        // ADD r1,r2,r3 from the file
        if_valid = 1'b1; if_pc = 32'h4;
        if_inst = mk(6'h20, 5'd1, 5'd2, {5'd3, 11'd0});
        step();
        chk("add_a", rf_a, 32'd5);
        chk("add_b", rf_b, 32'd7);

        // ADDC r4,r31,-1 while the ALU targets r31 with an unfinished value
        alu_wen = 1'b1; alu_wa = 5'd31; alu_wd = 32'h123; alu_wd_ok = 1'b0;
        if_inst = mk(6'h30, 5'd4, 5'd31, 16'hFFFF); if_pc = 32'h8;
        step();
        chk("addc_b", rf_b, 32'hFFFF_FFFF);

        // bypass priority on r2
        alu_wen = 1'b1; alu_wa = 5'd2; alu_wd = 32'hA; alu_wd_ok = 1'b1;
        mem_wen = 1'b1; mem_wa = 5'd2; mem_wd = 32'hB;
        wb_wen  = 1'b1; wb_wa  = 5'd2; wb_wd  = 32'hC;
        if_inst = mk(6'h30, 5'd7, 5'd2, 16'h0001); if_pc = 32'hC;
        step();
        chk("prio_alu", rf_a, 32'hA);
        alu_wen = 1'b0;
        step();
        chk("prio_mem", rf_a, 32'hB);
        mem_wen = 1'b0;
        step();
        chk("prio_wb", rf_a, 32'hC);

        // load-use: LD r1 still in ALU, then final in MEM
        idle_stages();
        alu_wen = 1'b1; alu_wa = 5'd1; alu_wd = 32'h0; alu_wd_ok = 1'b0;
        if_inst = mk(6'h20, 5'd5, 5'd1, {5'd1, 11'd0}); if_pc = 32'h10;
        step();
        chk1("lu_bubble", rf_valid, 1'b0);
        alu_wen = 1'b0;
        mem_wen = 1'b1; mem_wa = 5'd1; mem_wd = 32'h77; mem_wd_ok = 1'b1;
        step();
        chk("lu_a", rf_a, 32'h77);

        // ST r6 under ex_hold and flush, then free
        idle_stages();
        ex_hold = 1'b1; flush = 1'b1;
        if_inst = mk(6'h19, 5'd6, 5'd2, 16'h0010); if_pc = 32'h14;
        step();
        ex_hold = 1'b0; flush = 1'b0;
        step();
        chk("st_data", rf_st_data, 32'h66);

        // reset in the middle of a hazard stall
        alu_wen = 1'b1; alu_wa = 5'd1; alu_wd_ok = 1'b0;
        if_inst = mk(6'h20, 5'd5, 5'd1, {5'd1, 11'd0}); if_pc = 32'h18;
        step();
        #2 rst_n = 1'b0;
        #1;
        clear_model();
        check_regs();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // illegal opcode 0x00 touching a pending register never stalls
        if_inst = mk(6'h00, 5'd1, 5'd1, {5'd1, 11'd0}); if_pc = 32'h1C;
        step();
        chk1("illop", rf_illop, 1'b1);

        // random traffic
        for (int n = 0; n < 300; n++) begin
            logic [5:0] ops [10];
            ops = '{6'h20, 6'h30, 6'h18, 6'h19, 6'h1B, 6'h1C, 6'h1D, 6'h1F, 6'h00, 6'h05};
            if_valid  = ($urandom_range(0, 7) != 0);
            if_inst   = mk(($urandom_range(0, 9) == 9) ? 6'($urandom) : ops[$urandom_range(0, 9)],
                           rreg(), rreg(), {rreg(), 11'($urandom)});
            if_pc     = $urandom;
            alu_wen   = 1'($urandom); alu_wa = rreg(); alu_wd = $urandom;
            mem_wen   = 1'($urandom); mem_wa = rreg(); mem_wd = $urandom;
            wb_wen    = 1'($urandom); wb_wa  = rreg(); wb_wd  = $urandom;
            alu_wd_ok = ($urandom_range(0, 3) != 0);
            mem_wd_ok = ($urandom_range(0, 3) != 0);
            ex_hold   = ($urandom_range(0, 5) == 0);
            flush     = ($urandom_range(0, 5) == 0);
            file_m[$urandom_range(0, 7)] = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
